// File: rtl/vga_timing_generator.sv
// VGA raster timing: free-running X/Y counters, sync/blank generation delayed to line up with the pixel stage.
// Optional `VGA_FRAME_COUNTER_EN adds an 8-bit FrameCount output that counts FrameStart pulses.
module vga_timing_generator #(
    parameter int H_VISIBLE    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int CNTR_WIDTH_H = 10,
    parameter int CNTR_WIDTH_V = 10,
    parameter int PIPE_DELAY   = 1,
    parameter int R_WIDTH      = 8,
    parameter int G_WIDTH      = 8,
    parameter int B_WIDTH      = 8
) (
    input  logic                                 CLOCK,
    input  logic                                 RESET_N,
    input  logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]   RGB_In,
    output logic [CNTR_WIDTH_H-1:0]              CounterX,
    output logic [CNTR_WIDTH_V-1:0]              CounterY,
    output logic [R_WIDTH-1:0]                   VGA_R,
    output logic [G_WIDTH-1:0]                   VGA_G,
    output logic [B_WIDTH-1:0]                   VGA_B,
    output logic                                 VGA_HS,
    output logic                                 VGA_VS,
    output logic                                 VGA_BLANK_N,
    output logic                                 VGA_SYNC_N,
    output logic                                 FrameStart
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [7:0]                           FrameCount
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int STAGES  = PIPE_DELAY + 1;
    localparam int RGB_W   = R_WIDTH + G_WIDTH + B_WIDTH;

    localparam logic [CNTR_WIDTH_H-1:0] H_LAST      = CNTR_WIDTH_H'(H_TOTAL - 1);
    localparam logic [CNTR_WIDTH_H-1:0] H_VIS_END   = CNTR_WIDTH_H'(H_VISIBLE);
    localparam logic [CNTR_WIDTH_H-1:0] H_SYNC_BEG  = CNTR_WIDTH_H'(H_VISIBLE + H_FRONT);
    localparam logic [CNTR_WIDTH_H-1:0] H_SYNC_END  = CNTR_WIDTH_H'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNTR_WIDTH_V-1:0] V_LAST      = CNTR_WIDTH_V'(V_TOTAL - 1);
    localparam logic [CNTR_WIDTH_V-1:0] V_VIS_END   = CNTR_WIDTH_V'(V_VISIBLE);
    localparam logic [CNTR_WIDTH_V-1:0] V_SYNC_BEG  = CNTR_WIDTH_V'(V_VISIBLE + V_FRONT);
    localparam logic [CNTR_WIDTH_V-1:0] V_SYNC_END  = CNTR_WIDTH_V'(V_VISIBLE + V_FRONT + V_SYNC);

    // Delay-stage word is {hsync, vsync, active}; idle means syncs released and blanked.
    localparam logic [2:0] PIPE_IDLE = 3'b110;

    logic [CNTR_WIDTH_H-1:0] x_q, x_d;
    logic [CNTR_WIDTH_V-1:0] y_q, y_d;
    logic                    run_q, run_d;
    logic [2:0]              pipe_q [STAGES];
    logic [2:0]              pipe_d [STAGES];
    logic [RGB_W-1:0]        rgb_q, rgb_d;
    logic                    raw_hs, raw_vs, raw_act;
    logic                    frame_start;

    // run_q holds the counters at (0,0) for the first clock after reset so FrameStart is seen there.
    assign frame_start = run_q && (x_q == '0) && (y_q == '0);

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        run_d = 1'b1;
        if (run_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + CNTR_WIDTH_V'(1);
            end else begin
                x_d = x_q + CNTR_WIDTH_H'(1);
            end
        end

        raw_hs  = !(run_q && (x_q >= H_SYNC_BEG) && (x_q < H_SYNC_END));
        raw_vs  = !(run_q && (y_q >= V_SYNC_BEG) && (y_q < V_SYNC_END));
        raw_act = run_q && (x_q < H_VIS_END) && (y_q < V_VIS_END);

        pipe_d[0] = {raw_hs, raw_vs, raw_act};
        for (int i = 1; i < STAGES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        rgb_d = RGB_In;
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            x_q   <= '0;
            y_q   <= '0;
            run_q <= 1'b0;
            rgb_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                pipe_q[i] <= PIPE_IDLE;
            end
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            run_q <= run_d;
            rgb_q <= rgb_d;
            for (int i = 0; i < STAGES; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] fc_q, fc_d;

    always_comb begin
        fc_d = fc_q;
        if (frame_start) begin
            fc_d = fc_q + 8'd1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign FrameCount = fc_q;
`endif

    assign CounterX    = x_q;
    assign CounterY    = y_q;
    assign FrameStart  = frame_start;
    assign VGA_HS      = pipe_q[STAGES-1][2];
    assign VGA_VS      = pipe_q[STAGES-1][1];
    assign VGA_BLANK_N = pipe_q[STAGES-1][0];
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = VGA_BLANK_N ? rgb_q[RGB_W-1 -: R_WIDTH]           : '0;
    assign VGA_G       = VGA_BLANK_N ? rgb_q[G_WIDTH+B_WIDTH-1 -: G_WIDTH] : '0;
    assign VGA_B       = VGA_BLANK_N ? rgb_q[B_WIDTH-1:0]                  : '0;

endmodule

// File: doc/vga_timing_generator.md
VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

Interface
REQ-001 Parameter H_VISIBLE, default 640, sets the active pixels per line.
REQ-002 Parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, set the horizontal porch and sync widths in clocks.
REQ-003 Parameter V_VISIBLE, default 480, sets the active lines per frame.
REQ-004 Parameters V_FRONT/V_SYNC/V_BACK, defaults 10/2/33, set the vertical porch and sync widths in lines.
REQ-005 Parameters CNTR_WIDTH_H/CNTR_WIDTH_V, default 10/10, set the counter widths.
REQ-006 Parameter PIPE_DELAY, default 1, is the latency of the downstream image stage from CounterX/CounterY to RGB_In.
REQ-007 Parameters R_WIDTH/G_WIDTH/B_WIDTH, default 8 each, set the colour widths.
REQ-008 Port CLOCK  input  1  is the single pixel clock; all logic is clocked on its rising edge.
REQ-009 Port RESET_N  input  1  is a synchronous, active-low reset.
REQ-010 Port RGB_In  input  R+G+B  carries the pixel from the image/highlight stage, valid PIPE_DELAY clocks after its counters.
REQ-011 Port CounterX  output  CNTR_WIDTH_H  is the current horizontal position, raw and undelayed.
REQ-012 Port CounterY  output  CNTR_WIDTH_V  is the current vertical position, raw and undelayed.
REQ-013 Ports VGA_R/VGA_G/VGA_B  output  8 each  carry the registered, blank-gated colour.
REQ-014 Ports VGA_HS/VGA_VS  output  1 each  are active-low syncs aligned to VGA_R/G/B.
REQ-015 Port VGA_BLANK_N  output  1  is high only for aligned visible pixels.
REQ-016 Port VGA_SYNC_N  output  1  is tied to 0.
REQ-017 Port FrameStart  output  1  is a one-clock pulse when CounterX=0 and CounterY=0, undelayed.

Function
REQ-018 CounterX SHALL increment every clock and wrap from H_TOTAL-1 to 0, where H_TOTAL is the sum of the four horizontal parameters (800 by default).
REQ-019 CounterY SHALL increment only on the CounterX wrap and wrap from V_TOTAL-1 to 0 (V_TOTAL 525 by default); a simultaneous X and Y wrap SHALL return both to 0.
REQ-020 The raw hsync SHALL be low for CounterX in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751 by default).
REQ-021 The raw vsync SHALL be low for CounterY in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491 by default).
REQ-022 Raw active SHALL equal (CounterX<H_VISIBLE) AND (CounterY<V_VISIBLE).
REQ-023 Raw hsync, vsync and active SHALL pass through a shift register of PIPE_DELAY+1 stages to drive VGA_HS, VGA_VS and VGA_BLANK_N.
REQ-024 RGB_In SHALL be registered once; VGA_R/G/B SHALL be the registered value when the aligned active is 1, else 0.
REQ-025 Total latency from a counter value to its VGA outputs SHALL be exactly PIPE_DELAY+1 clocks.
REQ-026 PIPE_DELAY=0 SHALL be legal and give a 1-clock latency.
REQ-027 FrameStart SHALL never assert for two consecutive clocks.

Reset
REQ-028 While RESET_N=0 at a clock edge, the following SHALL hold: CounterX=0, CounterY=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0, FrameStart=0, all delay stages inactive (sync 1, active 0).
REQ-029 A reset asserted mid-frame SHALL take effect at the next edge; the first clock after release SHALL show CounterX=0, CounterY=0, FrameStart=1.
REQ-030 After release, VGA_BLANK_N SHALL stay 0 until the first valid pixel emerges, PIPE_DELAY+1 clocks later.

Configuration
REQ-031 With VGA_FRAME_COUNTER_EN defined, an output FrameCount[7:0] SHALL exist; it resets to 0 and increments on each FrameStart, wrapping from 255 to 0.
REQ-032 Without VGA_FRAME_COUNTER_EN, the FrameCount port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Release reset, count 420000 clocks -> counters return to (0,0) and FrameStart pulses exactly twice (clock 0 and clock 420000).
REQ-034 Defaults, PIPE_DELAY=1 -> VGA_HS falls 2 clocks after CounterX=656 and stays low exactly 96 clocks per line.
REQ-035 Drive RGB_In=24'hFF0000 constantly -> VGA_R=FF only while VGA_BLANK_N=1; VGA_BLANK_N is high 640 clocks per visible line and 480 lines per frame.
REQ-036 Assert reset at CounterX=300, CounterY=200 for 3 clocks -> all outputs equal reset values; after release, counting restarts at (0,0) with FrameStart=1.
REQ-037 VGA_VS low for exactly 1600 clocks (2 lines), starting 2 clocks after (X=0, Y=490).
REQ-038 VGA_FRAME_COUNTER_EN defined, run 257 frames -> FrameCount wraps from 255 to 0, then reads 1.
